// File: rtl/micro_sequencer.sv
// Control-store address sequencer: picks the next microaddress from the MIR
// condition/jump fields and holds the microprogram while main memory is busy.
module micro_sequencer #(
    parameter int unsigned DATAWIDTH_JUMPADDRESS = 11,
    parameter int unsigned DATAWIDTH_CONDITION   = 3,
    parameter int unsigned DATAWIDTH_CYCLECOUNT  = 16
) (
    input  logic                             MICRO_SEQUENCER_CLOCK_50,
    input  logic                             MICRO_SEQUENCER_ResetInHigh_In,
    input  logic [DATAWIDTH_CONDITION-1:0]   MICRO_SEQUENCER_Condition_InBus,
    input  logic [DATAWIDTH_JUMPADDRESS-1:0] MICRO_SEQUENCER_JumpAddress_InBus,
    input  logic                             MICRO_SEQUENCER_RD_In,
    input  logic                             MICRO_SEQUENCER_WRMain_In,
    input  logic                             MICRO_SEQUENCER_MemReady_In,
    input  logic [31:0]                      MICRO_SEQUENCER_IR_InBus,
    input  logic [3:0]                       MICRO_SEQUENCER_PSR_InBus,
    output logic [DATAWIDTH_JUMPADDRESS-1:0] MICRO_SEQUENCER_CSAddress_OutBus,
    output logic                             MICRO_SEQUENCER_Stall_Out,
    output logic [DATAWIDTH_CYCLECOUNT-1:0]  MICRO_SEQUENCER_CycleCount_OutBus
);

    localparam int unsigned AW = DATAWIDTH_JUMPADDRESS;
    localparam int unsigned CW = DATAWIDTH_CYCLECOUNT;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_csaddr;
    logic [CW-1:0]   r_count;

    logic [AW-1:0]   w_incr;
    logic [AW-1:0]   w_next;
    logic [AW-1:0]   w_decode;
    logic            w_mem;
    logic            w_flag_n;
    logic            w_flag_z;
    logic            w_flag_v;
    logic            w_flag_c;
    logic            w_unused_ir;

    assign w_flag_n = MICRO_SEQUENCER_PSR_InBus[3];
    assign w_flag_z = MICRO_SEQUENCER_PSR_InBus[2];
    assign w_flag_v = MICRO_SEQUENCER_PSR_InBus[1];
    assign w_flag_c = MICRO_SEQUENCER_PSR_InBus[0];

    // DECODE dispatch: op/op3 fields of the IR land in the upper half of the store
    assign w_decode = AW'({1'b1, MICRO_SEQUENCER_IR_InBus[31:30],
                           MICRO_SEQUENCER_IR_InBus[24:19], 2'b00});

    assign w_unused_ir = ^{MICRO_SEQUENCER_IR_InBus[29:25],
                           MICRO_SEQUENCER_IR_InBus[18:14],
                           MICRO_SEQUENCER_IR_InBus[12:0]};

    assign w_incr = r_csaddr + AW'(1);
    assign w_mem  = MICRO_SEQUENCER_RD_In | MICRO_SEQUENCER_WRMain_In;

    // Next-address mux
    always_comb begin
        w_next = w_incr;
        case (MICRO_SEQUENCER_Condition_InBus)
            3'b001:  if (w_flag_n) w_next = MICRO_SEQUENCER_JumpAddress_InBus;
            3'b010:  if (w_flag_z) w_next = MICRO_SEQUENCER_JumpAddress_InBus;
            3'b011:  if (w_flag_c) w_next = MICRO_SEQUENCER_JumpAddress_InBus;
            3'b100:  if (w_flag_v) w_next = MICRO_SEQUENCER_JumpAddress_InBus;
            3'b101:  if (MICRO_SEQUENCER_IR_InBus[13]) w_next = MICRO_SEQUENCER_JumpAddress_InBus;
            3'b110:  w_next = w_decode;
            3'b111:  w_next = MICRO_SEQUENCER_JumpAddress_InBus;
            default: w_next = w_incr;
        endcase
    end

    // Sequencer FSM: advance on every cycle unless a memory access is pending
    always_ff @(posedge MICRO_SEQUENCER_CLOCK_50) begin
        if (MICRO_SEQUENCER_ResetInHigh_In) begin
            r_state  <= ST_RUN;
            r_csaddr <= '0;
            r_count  <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!w_mem || MICRO_SEQUENCER_MemReady_In) begin
                        r_csaddr <= w_next;
                        r_count  <= r_count + CW'(1);
                    end else begin
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (MICRO_SEQUENCER_MemReady_In) begin
                        r_csaddr <= w_next;
                        r_count  <= r_count + CW'(1);
                        r_state  <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // Stall is combinational so the datapath freezes in the very cycle the access starts
    assign MICRO_SEQUENCER_Stall_Out = !MICRO_SEQUENCER_ResetInHigh_In &&
        ((r_state == ST_WAIT) || (w_mem && !MICRO_SEQUENCER_MemReady_In));

    assign MICRO_SEQUENCER_CSAddress_OutBus  = r_csaddr;
    assign MICRO_SEQUENCER_CycleCount_OutBus = r_count;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed scoreboard bench for micro_sequencer.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cond;
    logic [10:0] jump;
    logic        rd;
    logic        wr;
    logic        ready;
    logic [31:0] ir;
    logic [3:0]  psr;
    logic [10:0] addr;
    logic        stall;
    logic [15:0] count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [10:0] a;
        logic [15:0] c;
        logic        s;
    } exp_t;

    exp_t q[$];

    micro_sequencer dut (
        .MICRO_SEQUENCER_CLOCK_50          (clk),
        .MICRO_SEQUENCER_ResetInHigh_In    (rst),
        .MICRO_SEQUENCER_Condition_InBus   (cond),
        .MICRO_SEQUENCER_JumpAddress_InBus (jump),
        .MICRO_SEQUENCER_RD_In             (rd),
        .MICRO_SEQUENCER_WRMain_In         (wr),
        .MICRO_SEQUENCER_MemReady_In       (ready),
        .MICRO_SEQUENCER_IR_InBus          (ir),
        .MICRO_SEQUENCER_PSR_InBus         (psr),
        .MICRO_SEQUENCER_CSAddress_OutBus  (addr),
        .MICRO_SEQUENCER_Stall_Out         (stall),
        .MICRO_SEQUENCER_CycleCount_OutBus (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Push the expected post-edge state, clock once, then pop and compare
    task automatic cyc(input string tag, input logic [10:0] ea, input logic [15:0] ec, input logic es);
        exp_t e;
        e.a = ea;
        e.c = ec;
        e.s = es;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'(q.size()), 32'd1);
        end else begin
            e = q.pop_front();
            chk({tag, "_addr"},  32'(addr),  32'(e.a));
            chk({tag, "_count"}, 32'(count), 32'(e.c));
            chk({tag, "_stall"}, 32'(stall), 32'(e.s));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cond = 3'b000; jump = '0; rd = 1'b0; wr = 1'b0;
        ready = 1'b0; ir = '0; psr = '0;
        @(negedge clk);

        cyc("rst0", 11'd0, 16'd0, 1'b0);
        cyc("rst1", 11'd0, 16'd0, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_addr",  32'(addr),  32'd0);
        chk("post_rst_count", 32'(count), 32'd0);
        cyc("seq1", 11'd1, 16'd1, 1'b0);
        cyc("seq2", 11'd2, 16'd2, 1'b0);

        // Back to 0, then a read with MemReady low for three edges
        cond = 3'b111; jump = 11'd0;
        cyc("jmp0", 11'd0, 16'd3, 1'b0);
        cond = 3'b000; rd = 1'b1; ready = 1'b0;
        #1;
        chk("stall_comb", 32'(stall), 32'd1);
        cyc("wait1", 11'd0, 16'd3, 1'b1);
        cyc("wait2", 11'd0, 16'd3, 1'b1);
        cyc("wait3", 11'd0, 16'd3, 1'b1);
        ready = 1'b1;
        cyc("wait_done", 11'd1, 16'd4, 1'b0);
        rd = 1'b0;
        wr = 1'b1;
        cyc("wr_ready", 11'd2, 16'd5, 1'b0);
        wr = 1'b0; ready = 1'b0;

        cond = 3'b110; ir = 32'h8080_0000;
        cyc("decode", 11'd1600, 16'd6, 1'b0);
        cond = 3'b101; jump = 11'd1603; ir = 32'h0000_2000;
        cyc("ir13_t", 11'd1603, 16'd7, 1'b0);
        ir = 32'h0;
        cyc("ir13_f", 11'd1604, 16'd8, 1'b0);
        cond = 3'b010; jump = 11'd100; psr = 4'b0100;
        cyc("z_t", 11'd100, 16'd9, 1'b0);
        psr = 4'b0000;
        cyc("z_f", 11'd101, 16'd10, 1'b0);
        cond = 3'b001; jump = 11'd500; psr = 4'b1000;
        cyc("n_t", 11'd500, 16'd11, 1'b0);
        cond = 3'b011; jump = 11'd700; psr = 4'b0001;
        cyc("c_t", 11'd700, 16'd12, 1'b0);
        cond = 3'b100; jump = 11'd900; psr = 4'b0010;
        cyc("v_t", 11'd900, 16'd13, 1'b0);
        psr = 4'b0001;
        cyc("v_f", 11'd901, 16'd14, 1'b0);
        psr = 4'b0000;

        cond = 3'b111; jump = 11'd2047;
        cyc("jmp2047", 11'd2047, 16'd15, 1'b0);
        cond = 3'b000;
        cyc("wrap", 11'd0, 16'd16, 1'b0);

        // Reset while waiting on memory
        rd = 1'b1; ready = 1'b0;
        cyc("wait_pre_rst", 11'd0, 16'd16, 1'b1);
        rst = 1'b1;
        #1;
        chk("stall_in_rst", 32'(stall), 32'd0);
        cyc("rst_in_wait", 11'd0, 16'd0, 1'b0);
        rst = 1'b0; rd = 1'b0;
        cyc("after_rst", 11'd1, 16'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
